// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Summary  : 256x9 instruction store with a zero-latency fetch port and a
//            byte-stream program loader that holds the core while loading.
//            Optional macro LOAD_CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter logic [7:0] LOAD_BASE      = 8'h00,
  parameter logic       ERR_ON_HI_BITS = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] i_Addres_Instr_Bus,
  output logic [8:0] o_Instruction,
  input  logic       i_Load_Start,
  input  logic [7:0] i_Load_Byte,
  input  logic       i_Load_Valid,
  output logic       o_Load_Ready,
  output logic       o_Core_Hold,
  output logic       o_Load_Done,
  output logic       o_Load_Err,
  output logic [8:0] o_Load_Count
);

`ifdef LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN = 3'd1, S_LO = 3'd2, S_HI = 3'd3, S_CHK = 3'd4, S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN = 3'd1, S_LO = 3'd2, S_HI = 3'd3, S_DONE = 3'd5
  } state_t;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic [8:0] r_mem [256];
  logic [7:0] r_ptr;
  logic [7:0] r_lo;
  logic [8:0] r_remaining;
  logic       r_err_pend;
  logic       r_hold;
  logic       r_err;
  logic [8:0] r_count;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] r_chk;
`endif

  logic w_ready;
  logic w_accept;
  logic w_last;
  logic w_hi_bad;
  logic w_we;

  assign o_Instruction = r_mem[i_Addres_Instr_Bus];
  assign o_Load_Ready  = w_ready;
  assign o_Core_Hold   = r_hold;
  assign o_Load_Err    = r_err;
  assign o_Load_Count  = r_count;

  assign w_last   = (r_remaining == 9'd1);
  assign w_hi_bad = ERR_ON_HI_BITS && (i_Load_Byte[7:1] != 7'd0);
  assign w_we     = w_accept && (r_state == S_HI) && !Rst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Start wins over a byte presented in the same cycle, so it masks acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    o_Load_Done = 1'b0;
    case (r_state)
      S_LEN, S_LO, S_HI: w_ready = 1'b1;
`ifdef LOAD_CHECKSUM_EN
      S_CHK:             w_ready = 1'b1;
`endif
      S_DONE: begin
        o_Load_Done = ~r_err_pend;
        w_state_nxt = S_IDLE;
      end
      default: ;
    endcase
    w_accept = w_ready & i_Load_Valid & ~i_Load_Start;
    if (w_accept) begin
      case (r_state)
        S_LEN: w_state_nxt = S_LO;
        S_LO:  w_state_nxt = S_HI;
`ifdef LOAD_CHECKSUM_EN
        S_HI:  w_state_nxt = w_last ? S_CHK : S_LO;
        S_CHK: w_state_nxt = S_DONE;
`else
        S_HI:  w_state_nxt = w_last ? S_DONE : S_LO;
`endif
        default: ;
      endcase
    end
    if (i_Load_Start) begin
      w_state_nxt = S_LEN;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr       <= LOAD_BASE;
      r_lo        <= 8'd0;
      r_remaining <= 9'd0;
      r_err_pend  <= 1'b0;
      r_hold      <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= 9'd0;
`ifdef LOAD_CHECKSUM_EN
      r_chk       <= 8'd0;
`endif
    end else if (i_Load_Start) begin
      r_ptr       <= LOAD_BASE;
      r_remaining <= 9'd0;
      r_err_pend  <= 1'b0;
      r_hold      <= 1'b1;
      r_err       <= 1'b0;
      r_count     <= 9'd0;
`ifdef LOAD_CHECKSUM_EN
      r_chk       <= 8'd0;
`endif
    end else begin
      if (w_accept) begin
`ifdef LOAD_CHECKSUM_EN
        r_chk <= r_chk ^ i_Load_Byte;
`endif
        case (r_state)
          S_LEN: r_remaining <= (i_Load_Byte == 8'd0) ? 9'd256 : {1'b0, i_Load_Byte};
          S_LO:  r_lo <= i_Load_Byte;
          S_HI: begin
            r_ptr       <= r_ptr + 8'd1;
            r_remaining <= r_remaining - 9'd1;
            if (r_count != 9'h100) begin
              r_count <= r_count + 9'd1;
            end
            if (w_hi_bad) begin
              r_err_pend <= 1'b1;
            end
          end
`ifdef LOAD_CHECKSUM_EN
          S_CHK: begin
            if (r_chk != i_Load_Byte) begin
              r_err_pend <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      // A failed load keeps the core held until some later load succeeds.
      if (r_state == S_DONE) begin
        if (r_err_pend) begin
          r_err <= 1'b1;
        end else begin
          r_hold <= 1'b0;
        end
        r_err_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[r_ptr] <= {i_Load_Byte[0], r_lo};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Summary  : Self-checking bench for instr_mem_loader (both LOAD_CHECKSUM_EN
//            builds); a second instance uses LOAD_BASE=8'hFF for wrap checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

`ifdef LOAD_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif
  localparam int BASE = 0;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] addr = 8'd0;
  logic [7:0] addr1 = 8'd0;
  logic       ld_start = 1'b0;
  logic [7:0] ld_byte = 8'd0;
  logic       ld_valid = 1'b0;
  logic [8:0] instr, instr1, count, count1;
  logic       ready, hold, done, err;
  logic       ready1, hold1, done1, err1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  instr_mem_loader #(.LOAD_BASE(8'h00), .ERR_ON_HI_BITS(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .i_Addres_Instr_Bus(addr), .o_Instruction(instr),
    .i_Load_Start(ld_start), .i_Load_Byte(ld_byte), .i_Load_Valid(ld_valid),
    .o_Load_Ready(ready), .o_Core_Hold(hold), .o_Load_Done(done),
    .o_Load_Err(err), .o_Load_Count(count)
  );

  instr_mem_loader #(.LOAD_BASE(8'hFF), .ERR_ON_HI_BITS(1'b1)) dut_ff (
    .Clk(Clk), .Rst(Rst), .i_Addres_Instr_Bus(addr1), .o_Instruction(instr1),
    .i_Load_Start(ld_start), .i_Load_Byte(ld_byte), .i_Load_Valid(ld_valid),
    .o_Load_Ready(ready1), .o_Core_Hold(hold1), .o_Load_Done(done1),
    .o_Load_Err(err1), .o_Load_Count(count1)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position of each accepted byte within the stream decides its role.
  bit         m_valid = 1'b0;
  bit         m_active = 1'b0;
  bit         m_in_done = 1'b0;
  bit         m_bad = 1'b0;
  bit         m_hold = 1'b0;
  bit         m_err = 1'b0;
  int         m_count = 0;
  int         m_idx = 0;
  int         m_n = 0;
  int         m_a = 0;
  logic [7:0] m_lo = 8'd0;
  logic [7:0] m_xor = 8'd0;
  logic [8:0] m_mem [256];
  bit         m_known [256];

  always @(posedge Clk) begin
    if (Rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_in_done = 1'b0; m_bad = 1'b0;
      m_hold = 1'b0; m_err = 1'b0; m_count = 0;
    end else if (ld_start) begin
      m_active = 1'b1; m_in_done = 1'b0; m_bad = 1'b0; m_hold = 1'b1;
      m_err = 1'b0; m_count = 0; m_idx = 0; m_xor = 8'd0;
    end else if (m_in_done) begin
      if (m_bad) m_err = 1'b1;
      else       m_hold = 1'b0;
      m_in_done = 1'b0; m_active = 1'b0; m_bad = 1'b0;
    end else if (m_active && ld_valid) begin
      if (m_idx == 0) begin
        m_n = (ld_byte == 8'd0) ? 256 : int'(ld_byte);
      end else if (m_idx <= 2 * m_n) begin
        if (m_idx % 2 == 1) begin
          m_lo = ld_byte;
        end else begin
          m_a = (BASE + m_idx / 2 - 1) % 256;
          m_mem[m_a] = {ld_byte[0], m_lo};
          m_known[m_a] = 1'b1;
          if (m_count < 256) m_count++;
          if (ld_byte[7:1] != 7'd0) m_bad = 1'b1;
        end
      end else if (ld_byte != m_xor) begin
        m_bad = 1'b1;
      end
      m_xor = m_xor ^ ld_byte;
      m_idx++;
      if (m_idx == 1 + 2 * m_n + CHK_BYTES) m_in_done = 1'b1;
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      check("ready", 9'(ready), 9'(m_active && !m_in_done));
      check("done",  9'(done),  9'(m_in_done && !m_bad));
      check("hold",  9'(hold),  9'(m_hold));
      check("err",   9'(err),   9'(m_err));
      check("count", count, 9'(m_count));
      if (m_known[addr]) check("instr", instr, m_mem[addr]);
      if (done) n_done++;
    end
  end

  logic [7:0] lob [256];
  logic [7:0] hib [256];

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    if (rnd) begin
      ld_valid = 1'b0;
      for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) tick();
    end
    ld_byte = b;
    ld_valid = 1'b1;
    while (!ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake: ready=%b expected 1 for byte %h", ready, b);
    end
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic do_load(input int n, input bit bad, input bit rnd);
    logic [7:0] x;
    logic [7:0] hb;
    x = 8'(n);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send_byte(x, rnd);
    for (int i = 0; i < n; i++) begin
      hb = hib[i];
`ifndef LOAD_CHECKSUM_EN
      if (bad && i == 0) hb = hb | 8'h02;
`endif
      send_byte(lob[i], rnd);
      send_byte(hb, rnd);
      x = x ^ lob[i] ^ hb;
    end
`ifdef LOAD_CHECKSUM_EN
    send_byte(x ^ {7'd0, bad}, rnd);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_hold", 9'(hold), 9'd0);
    check("rst_ready", 9'(ready), 9'd0);
    check("rst_done", 9'(done), 9'd0);
    check("rst_err", 9'(err), 9'd0);
    check("rst_count", count, 9'd0);
    Rst = 1'b0;
    tick();

    // Basic two-word load; address 01 watched through the DONE cycle
    lob[0] = 8'h34; hib[0] = 8'h01; lob[1] = 8'h12; hib[1] = 8'h00;
    addr = 8'h01;
    n_done = 0;
    do_load(2, 1'b0, 1'b0);
    check("t2_done_pulse", 9'(done), 9'd1);
    check("t2_hold_in_done", 9'(hold), 9'd1);
    check("t2_instr01", instr, 9'h012);
    tick();
    check("t2_hold_released", 9'(hold), 9'd0);
    check("t2_done_once", 9'(n_done), 9'd1);
    check("t2_count", count, 9'd2);
    addr = 8'h00;
    #1;
    check("t2_instr00", instr, 9'h134);

    // Failing load then recovery
    n_done = 0;
    do_load(2, 1'b1, 1'b0);
    tick();
    check("t3_err", 9'(err), 9'd1);
    check("t3_hold", 9'(hold), 9'd1);
    check("t3_no_done", 9'(n_done), 9'd0);
    do_load(2, 1'b0, 1'b0);
    tick();
    check("t3_err_cleared", 9'(err), 9'd0);
    check("t3_hold_released", 9'(hold), 9'd0);

    // Wrap at the top of memory on the LOAD_BASE=FF instance
    lob[0] = 8'hAA; hib[0] = 8'h00; lob[1] = 8'h55; hib[1] = 8'h01;
    addr1 = 8'hFF;
    do_load(2, 1'b0, 1'b0);
    tick();
    check("t4_memFF", instr1, 9'h0AA);
    addr1 = 8'h00;
    #1;
    check("t4_mem00", instr1, 9'h155);
    check("t4_count", count1, 9'd2);
    check("t4_err", 9'(err1), 9'd0);
    check("t4_hold", 9'(hold1), 9'd0);
    check("t4_ready", 9'(ready1), 9'd0);
    check("t4_done", 9'(done1), 9'd0);

    // Restart mid-load with a byte presented in the same cycle
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send_byte(8'h05, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h01, 1'b0);
    check("t5_count_before", count, 9'd1);
    ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h22;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    check("t5_ready", 9'(ready), 9'd1);
    check("t5_count", count, 9'd0);
    check("t5_hold", 9'(hold), 9'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h01, 1'b0);
`ifdef LOAD_CHECKSUM_EN
    send_byte(8'h56, 1'b0);
`endif
    tick();
    addr = 8'h00;
    #1;
    check("t5_instr00", instr, 9'h156);
    check("t5_hold_released", 9'(hold), 9'd0);

    // Full 256-word load, gappy valid, one bad high byte
    for (int i = 0; i < 256; i++) begin
      lob[i] = 8'(i) ^ 8'h5A;
      hib[i] = {7'd0, 1'(i)};
    end
    hib[100] = 8'h02;
    do_load(256, 1'b0, 1'b1);
    tick();
    check("t6_count", count, 9'h100);
    check("t6_err", 9'(err), 9'd1);
    check("t6_hold", 9'(hold), 9'd1);
    for (int a = 0; a < 256; a++) begin
      addr = 8'(a);
      tick();
    end
    addr = 8'd0;
    #1;
    check("t6_instr00", instr, 9'h05A);
    addr = 8'd100;
    #1;
    check("t6_instr100", instr, 9'h03E);
    addr = 8'hFF;
    #1;
    check("t6_instrFF", instr, 9'h1A5);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
